// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 shift-add multiply sequencer that borrows the shared EX-stage ALU and stalls the pipeline.
// Define MUL_SIGNED_EN to build the operand/result negate states for two's-complement multiplies.
`ifndef ADD
`define ADD 5'h01
`endif
`ifndef SUB
`define SUB 5'h02
`endif
`ifndef SUBC
`define SUBC 5'h03
`endif
module alu_mul_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  input  logic        mul_signed,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        stall,
  input  logic [15:0] pipe_ir,
  input  logic [15:0] pipe_a,
  input  logic [15:0] pipe_b,
  input  logic        pipe_cfin,
  output logic [15:0] alu_ir,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cfin,
  input  logic [15:0] alu_o,
  input  logic        alu_cf
);
  typedef enum logic [2:0] {IDLE, NEGA, NEGB, MUL, NEGL, NEGH, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] mcand_q, mcand_d, lo_q, lo_d, hi_q, hi_d, seq_a, seq_b;
  logic [31:0] product_q, product_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] op;
  logic sgn_q, sgn_d, neg_q, neg_d, borrow_q, borrow_d, seq_cfin, own;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    lo_d = lo_q;
    hi_d = hi_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    neg_d = neg_q;
    borrow_d = borrow_q;
    product_d = product_q;
    op = `ADD;
    seq_a = '0;
    seq_b = '0;
    seq_cfin = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        mcand_d = mul_a;
        lo_d = mul_b;
        hi_d = '0;
        cnt_d = '0;
`ifdef MUL_SIGNED_EN
        sgn_d = mul_signed;
        neg_d = mul_signed & (mul_a[15] ^ mul_b[15]);
        state_d = NEGA;
`else
        state_d = MUL;
`endif
      end
`ifdef MUL_SIGNED_EN
      NEGA: begin
        op = `SUB;
        seq_b = mcand_q;
        mcand_d = (sgn_q & mcand_q[15]) ? alu_o : mcand_q;
        state_d = NEGB;
      end
      NEGB: begin
        op = `SUB;
        seq_b = lo_q;
        lo_d = (sgn_q & lo_q[15]) ? alu_o : lo_q;
        state_d = MUL;
      end
      NEGL: begin
        op = `SUB;
        seq_b = lo_q;
        lo_d = neg_q ? alu_o : lo_q;
        borrow_d = neg_q ? alu_cf : borrow_q;
        state_d = NEGH;
      end
      NEGH: begin
        op = `SUBC;
        seq_b = hi_q;
        seq_cfin = borrow_q;
        hi_d = neg_q ? alu_o : hi_q;
        state_d = DONE;
      end
`endif
      MUL: begin
        seq_a = hi_q;
        seq_b = lo_q[0] ? mcand_q : '0;
        hi_d = {alu_cf, alu_o[15:1]};
        lo_d = {alu_o[0], lo_q[15:1]};
        cnt_d = cnt_q + 4'd1;
`ifdef MUL_SIGNED_EN
        state_d = (cnt_q == 4'd15) ? NEGL : MUL;
`else
        state_d = (cnt_q == 4'd15) ? DONE : MUL;
`endif
      end
      DONE: begin
        product_d = {hi_q, lo_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
      borrow_q <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      neg_q <= neg_d;
      borrow_q <= borrow_d;
      product_q <= product_d;
    end
  end
`ifndef MUL_SIGNED_EN
  logic unused_ok;
  assign unused_ok = ^{mul_signed, sgn_q, neg_q, borrow_q};
`endif
  assign own = (state_q != IDLE) && (state_q != DONE);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign stall = own;
  // DONE shows the fresh result combinationally so it is valid alongside the done pulse
  assign product = done ? {hi_q, lo_q} : product_q;
  assign alu_ir = own ? {op, 11'b0} : pipe_ir;
  assign alu_a = own ? seq_a : pipe_a;
  assign alu_b = own ? seq_b : pipe_b;
  assign alu_cfin = own ? seq_cfin : pipe_cfin;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized self-checking bench for alu_mul_seq with a behavioural ALU and product model.
`ifndef ADD
`define ADD 5'h01
`endif
`ifndef SUB
`define SUB 5'h02
`endif
`ifndef SUBC
`define SUBC 5'h03
`endif
module tb_alu_mul_seq;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, mul_signed = 1'b0, pipe_cfin = 1'b0;
  logic [15:0] mul_a = '0, mul_b = '0, pipe_ir = '0, pipe_a = '0, pipe_b = '0;
  logic busy, done, stall, alu_cfin, alu_cf;
  logic [31:0] product;
  logic [15:0] alu_ir, alu_a, alu_b, alu_o;
  logic [16:0] r;
  int checks = 0, errors = 0;
`ifdef MUL_SIGNED_EN
  localparam int NST = 20;
`else
  localparam int NST = 16;
`endif
  alu_mul_seq dut (
    .clock(clock), .reset(reset), .start(start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_signed(mul_signed), .busy(busy), .done(done), .product(product), .stall(stall),
    .pipe_ir(pipe_ir), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_cfin(pipe_cfin),
    .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_cfin(alu_cfin),
    .alu_o(alu_o), .alu_cf(alu_cf)
  );
  always #5 clock = ~clock;
  always_comb begin
    r = {1'b0, alu_a ^ alu_b};
    if (alu_ir[15:11] == `ADD) r = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, alu_cfin};
    else if (alu_ir[15:11] == `SUB) r = {1'b0, alu_a} - {1'b0, alu_b};
    else if (alu_ir[15:11] == `SUBC) r = {1'b0, alu_a} - {1'b0, alu_b} - {16'b0, alu_cfin};
    alu_o = r[15:0];
    alu_cf = r[16];
  end
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] x, y;
    x = $signed(a);
    y = $signed(b);
`ifdef MUL_SIGNED_EN
    if (s) return x * y;
`endif
    return {16'b0, a} * {16'b0, b};
  endfunction
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, stall} !== 3'b000 || product !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy/done/stall=%b product=%h required 000 00000000", {busy, done, stall}, product);
    end
    reset = 1'b1;
  endtask
  task automatic test_passthrough();
    pipe_ir = 16'h1234; pipe_a = 16'd5; pipe_b = 16'd7; pipe_cfin = 1'b1;
    @(negedge clock);
    checks++;
    if (alu_ir !== 16'h1234 || alu_a !== 16'd5 || alu_b !== 16'd7 || alu_cfin !== 1'b1 || stall !== 1'b0 || busy !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("FAIL passthrough: ir=%h a=%h b=%h cfin=%b stall=%b busy=%b product=%h required 1234 0005 0007 1 0 0 0", alu_ir, alu_a, alu_b, alu_cfin, stall, busy, product);
    end
  endtask
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic s, input bit poke, input string nm);
    logic [31:0] exp;
    int st, n;
    exp = model(a, b, s);
    @(negedge clock);
    start = 1'b1; mul_a = a; mul_b = b; mul_signed = s;
    @(negedge clock);
    start = 1'b0; mul_a = 16'($urandom); mul_b = 16'($urandom); mul_signed = 1'($urandom);
    st = 0; n = 0;
    while (!done && n < 40) begin
      if (stall) st++;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: cycle %0d busy=%b required 1", nm, n, busy);
      end
      start = poke && n == 5;
      @(negedge clock);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done=%b required 1 within 40 cycles", nm, done);
    end
    checks++;
    if (st != NST || n != NST) begin
      errors++;
      $display("FAIL %s latency: stall cycles=%0d cycles to done=%0d required %0d", nm, st, n, NST);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s product: got %h required %h", nm, product, exp);
    end
    checks++;
    if (stall !== 1'b0 || busy !== 1'b1 || alu_ir !== pipe_ir || alu_a !== pipe_a || alu_b !== pipe_b) begin
      errors++;
      $display("FAIL %s done_cycle: stall=%b busy=%b alu_ir=%h alu_a=%h alu_b=%h required 0 1 %h %h %h", nm, stall, busy, alu_ir, alu_a, alu_b, pipe_ir, pipe_a, pipe_b);
    end
    start = poke;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b product=%h required 0 0 %h", nm, done, busy, product, exp);
    end
  endtask
  task automatic test_unsigned_max();
    run_mul(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "ffff_x_ffff");
  endtask
  task automatic test_signed();
`ifdef MUL_SIGNED_EN
    run_mul(16'hFFFD, 16'h0005, 1'b1, 1'b0, "neg3_x_5");
    run_mul(16'h8000, 16'h8000, 1'b1, 1'b0, "min_x_min");
    run_mul(16'h7FFF, 16'h8000, 1'b1, 1'b0, "max_x_min");
`endif
    run_mul(16'h8000, 16'h8000, 1'b0, 1'b0, "8000_x_8000_u");
  endtask
  task automatic test_start_ignored();
    run_mul(16'h1234, 16'h5678, 1'b0, 1'b1, "poke_first");
    run_mul(16'h0102, 16'h0304, 1'b0, 1'b0, "poke_next");
  endtask
  task automatic test_mid_reset();
    int n;
    @(negedge clock);
    start = 1'b1; mul_a = 16'hABCD; mul_b = 16'h1357; mul_signed = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (NST - 8) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    checks++;
    if ({busy, stall, done} !== 3'b000 || product !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: busy/stall/done=%b product=%h required 000 00000000", {busy, stall, done}, product);
    end
    n = 0;
    repeat (25) begin
      @(negedge clock);
      n += int'(done) + int'(busy);
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: done/busy cycles=%0d required 0", n);
    end
  endtask
  task automatic test_zero_one();
    run_mul(16'h0000, 16'hABCD, 1'b0, 1'b0, "zero_x_abcd");
    run_mul(16'h0001, 16'hABCD, 1'b0, 1'b0, "one_x_abcd");
    run_mul(16'hABCD, 16'h0000, 1'b1, 1'b0, "abcd_x_zero");
  endtask
  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      pipe_ir = 16'($urandom); pipe_a = 16'($urandom); pipe_b = 16'($urandom);
      run_mul(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");
    end
  endtask
  initial begin
    test_reset();
    test_passthrough();
    test_unsigned_max();
    test_signed();
    test_start_ignored();
    test_mid_reset();
    test_zero_one();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
